// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: shares dm_4k between the MEM stage and an
// external valid/ready requester, with starvation relief and bounded locked bursts.
module dm_arbiter #(
    parameter int AW           = 12,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p_valid,
    input  logic          p_we,
    input  logic          p_sb,
    input  logic          p_lb,
    input  logic          p_lbu,
    input  logic [AW-1:0] p_addr,
    input  logic [31:0]   p_wdata,
    output logic [31:0]   p_rdata,
    output logic          p_stall,
    input  logic          x_valid,
    input  logic          x_we,
    input  logic          x_sb,
    input  logic          x_lb,
    input  logic          x_lbu,
    input  logic          x_lock,
    input  logic [AW-1:0] x_addr,
    input  logic [31:0]   x_wdata,
    output logic          x_ready,
    output logic [31:0]   x_rdata,
    output logic          x_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    output logic          mem_sb,
    output logic          mem_lb,
    output logic          mem_lbu,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        XLOCK = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
    localparam logic       LOCK_EN    = (MAX_BURST > 1) ? 1'b1 : 1'b0;

    state_t      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [31:0] x_rdata_q, x_rdata_d;
    logic        x_rvalid_q, x_rvalid_d;

    logic        x_ready_s;
    logic        grant_x_s;
    logic        burst_last_s;

    // Readiness of the external port; forced low while reset is asserted.
    always_comb begin
        x_ready_s = 1'b0;
        if (!rst_n) begin
            x_ready_s = 1'b0;
        end else if (state_q == XLOCK) begin
            x_ready_s = 1'b1;
        end else begin
            x_ready_s = !p_valid || (starve_cnt_q == STARVE_MAX);
        end
    end

    assign grant_x_s    = x_valid && x_ready_s;
    assign burst_last_s = ((beat_cnt_q + 8'd1) == BURST_MAX);

    // Memory port mux: the granted external beat overrides the pipeline.
    always_comb begin
        mem_addr  = p_addr;
        mem_wdata = p_wdata;
        mem_sb    = p_sb;
        mem_lb    = p_lb;
        mem_lbu   = p_lbu;
        mem_we    = 1'b0;
        if (grant_x_s) begin
            mem_addr  = x_addr;
            mem_wdata = x_wdata;
            mem_sb    = x_sb;
            mem_lb    = x_lb;
            mem_lbu   = x_lbu;
            mem_we    = x_we;
        end else if (rst_n) begin
            mem_we    = p_valid && p_we;
        end else begin
            mem_we    = 1'b0;
        end
    end

    // Next-state logic for arbitration state, starvation and burst counters.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        x_rdata_d    = x_rdata_q;
        x_rvalid_d   = 1'b0;
        if (grant_x_s) begin
            x_rdata_d  = mem_rdata;
            x_rvalid_d = 1'b1;
        end else begin
            x_rdata_d  = x_rdata_q;
            x_rvalid_d = 1'b0;
        end
        case (state_q)
            ARB: begin
                if (grant_x_s) begin
                    starve_cnt_d = 4'd0;
                    if (x_lock && LOCK_EN) begin
                        state_d    = XLOCK;
                        beat_cnt_d = 8'd1;
                    end else begin
                        state_d    = ARB;
                    end
                end else if (x_valid && (starve_cnt_q != STARVE_MAX)) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end else begin
                    starve_cnt_d = starve_cnt_q;
                end
            end
            XLOCK: begin
                starve_cnt_d = 4'd0;
                if (!x_valid) begin
                    state_d    = ARB;
                    beat_cnt_d = 8'd0;
                end else if (!x_lock || burst_last_s) begin
                    // Exiting with starve_cnt at 0 hands the next cycle to the pipeline.
                    state_d    = ARB;
                    beat_cnt_d = 8'd0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d      = ARB;
                starve_cnt_d = 4'd0;
                beat_cnt_d   = 8'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            starve_cnt_q <= 4'd0;
            beat_cnt_q   <= 8'd0;
            x_rdata_q    <= 32'd0;
            x_rvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            x_rdata_q    <= x_rdata_d;
            x_rvalid_q   <= x_rvalid_d;
        end
    end

    assign x_ready  = x_ready_s;
    assign p_stall  = p_valid && grant_x_s;
    assign p_rdata  = mem_rdata;
    assign x_rdata  = x_rdata_q;
    assign x_rvalid = x_rvalid_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized and directed bench for dm_arbiter with a byte-array dm_4k model,
// a transaction-level reference model and an x_rvalid scoreboard.
module tb_dm_arbiter;

    localparam int AW           = 12;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_BURST    = 8;

    typedef struct packed {
        logic        v;
        logic        we;
        logic        sb;
        logic        lb;
        logic        lbu;
        logic        lock;
        logic [11:0] addr;
        logic [31:0] wd;
    } req_t;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p_valid, p_we, p_sb, p_lb, p_lbu;
    logic [AW-1:0] p_addr;
    logic [31:0]   p_wdata, p_rdata;
    logic          p_stall;
    logic          x_valid, x_we, x_sb, x_lb, x_lbu, x_lock;
    logic [AW-1:0] x_addr;
    logic [31:0]   x_wdata, x_rdata;
    logic          x_ready, x_rvalid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_we, mem_sb, mem_lb, mem_lbu;

    int tests = 0;
    int fails = 0;

    logic [7:0] dm      [0:4095];
    logic [7:0] ref_mem [0:4095];
    exp_t       sb_q[$];

    logic        m_burst;
    int          m_left;
    int          m_refused;
    logic        m_pstalled;
    logic        m_xrefused;
    int          stall_cnt;

    localparam req_t IDLE = '0;

    dm_arbiter #(.AW(AW), .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_we(p_we), .p_sb(p_sb), .p_lb(p_lb), .p_lbu(p_lbu),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata), .p_stall(p_stall),
        .x_valid(x_valid), .x_we(x_we), .x_sb(x_sb), .x_lb(x_lb), .x_lbu(x_lbu),
        .x_lock(x_lock), .x_addr(x_addr), .x_wdata(x_wdata), .x_ready(x_ready),
        .x_rdata(x_rdata), .x_rvalid(x_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_sb(mem_sb), .mem_lb(mem_lb), .mem_lbu(mem_lbu), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // dm_4k stand-in: little-endian words, byte stores, signed/unsigned byte loads.
    logic [11:0] wbase;
    logic [31:0] dm_word;
    logic [7:0]  dm_byte;
    assign wbase     = {mem_addr[11:2], 2'b00};
    assign dm_word   = {dm[wbase + 12'd3], dm[wbase + 12'd2], dm[wbase + 12'd1], dm[wbase]};
    assign dm_byte   = dm[mem_addr];
    assign mem_rdata = mem_lb  ? {{24{dm_byte[7]}}, dm_byte} :
                       mem_lbu ? {24'd0, dm_byte} : dm_word;

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_sb) begin
                dm[mem_addr] <= mem_wdata[7:0];
            end else begin
                dm[wbase]         <= mem_wdata[7:0];
                dm[wbase + 12'd1] <= mem_wdata[15:8];
                dm[wbase + 12'd2] <= mem_wdata[23:16];
                dm[wbase + 12'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input req_t r);
        logic [11:0] b;
        logic [7:0]  by;
        b  = {r.addr[11:2], 2'b00};
        by = ref_mem[r.addr];
        if (r.lb)       return {{24{by[7]}}, by};
        else if (r.lbu) return {24'd0, by};
        else            return {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
    endfunction

    task automatic ref_store(input req_t r);
        logic [11:0] b;
        b = {r.addr[11:2], 2'b00};
        if (r.sb) begin
            ref_mem[r.addr] = r.wd[7:0];
        end else begin
            for (int k = 0; k < 4; k++) ref_mem[b + 12'(k)] = r.wd[8*k +: 8];
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            dm[a + 12'(k)]      = w[8*k +: 8];
            ref_mem[a + 12'(k)] = w[8*k +: 8];
        end
    endtask

    function automatic req_t mk(input logic v, input logic we, input logic sb, input logic lb,
                                input logic lbu, input logic lock, input logic [11:0] a,
                                input logic [31:0] wd);
        req_t r;
        r.v = v; r.we = we; r.sb = sb; r.lb = lb; r.lbu = lbu; r.lock = lock;
        r.addr = a; r.wd = wd;
        return r;
    endfunction

    task automatic apply(input req_t p, input req_t x);
        p_valid = p.v;  p_we = p.we;  p_sb = p.sb;  p_lb = p.lb;  p_lbu = p.lbu;
        p_addr = p.addr; p_wdata = p.wd;
        x_valid = x.v;  x_we = x.we;  x_sb = x.sb;  x_lb = x.lb;  x_lbu = x.lbu;
        x_lock = x.lock; x_addr = x.addr; x_wdata = x.wd;
    endtask

    // One cycle: drive, compare against the rule-level model at negedge, advance.
    task automatic step(input req_t p, input req_t x);
        logic exp_ready, grant;
        exp_t e;
        apply(p, x);
        @(negedge clk);
        exp_ready = m_burst || !p.v || (m_refused == STARVE_LIMIT);
        grant     = x.v && exp_ready;
        chk("x_ready", {31'd0, x_ready}, {31'd0, exp_ready});
        chk("p_stall", {31'd0, p_stall}, {31'd0, p.v && grant});
        chk("mem_we", {31'd0, mem_we}, {31'd0, grant ? x.we : (p.v && p.we)});
        if (p_stall) stall_cnt++;
        if (p.v && !grant && !p.we) chk("p_rdata", p_rdata, ref_load(p));
        if (grant) begin
            e.is_read = !x.we;
            e.data    = x.we ? 32'd0 : ref_load(x);
            sb_q.push_back(e);
            if (x.we) ref_store(x);
        end else if (p.v && p.we) begin
            ref_store(p);
        end
        m_pstalled = p.v && grant;
        m_xrefused = x.v && !grant;
        if (m_burst) begin
            m_refused = 0;
            if (!x.v) begin
                m_burst = 1'b0;
            end else begin
                m_left--;
                if (!x.lock || m_left == 0) m_burst = 1'b0;
            end
        end else if (grant) begin
            m_refused = 0;
            if (x.lock && MAX_BURST > 1) begin
                m_burst = 1'b1;
                m_left  = MAX_BURST - 1;
            end
        end else if (x.v && m_refused < STARVE_LIMIT) begin
            m_refused++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_burst = 1'b0; m_left = 0; m_refused = 0;
        m_pstalled = 1'b0; m_xrefused = 1'b0;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        apply(IDLE, IDLE);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every x_rvalid pulse retires one expected beat.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (rst_n && x_rvalid) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL x_rvalid_unexpected at %0t: got 1 expected 0", $time);
            end else begin
                e = sb_q.pop_front();
                if (e.is_read) chk("x_rdata", x_rdata, e.data);
            end
        end
    end

    function automatic req_t rnd_req(input logic allow_lock);
        req_t r;
        r      = '0;
        r.v    = ($urandom_range(0, 9) < 7);
        r.we   = 1'($urandom_range(0, 1));
        r.wd   = $urandom;
        r.lock = allow_lock && ($urandom_range(0, 1) == 1);
        if (r.we) begin
            r.sb = 1'($urandom_range(0, 1));
        end else begin
            case ($urandom_range(0, 2))
                0:       r.lb  = 1'b1;
                1:       r.lbu = 1'b1;
                default: r.lb  = 1'b0;
            endcase
        end
        if (r.sb || r.lb || r.lbu) r.addr = 12'($urandom_range(0, 127));
        else                       r.addr = {5'd0, 5'($urandom_range(0, 31)), 2'b00};
        return r;
    endfunction

    initial begin
        req_t p, x, pr;
        logic [31:0] w;
        for (int i = 0; i < 4096; i++) begin
            dm[i]      = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        model_reset();
        stall_cnt = 0;
        apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0),
              mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0, 32'h0));
        #1;
        chk("rst_x_ready", {31'd0, x_ready}, 32'd0);
        chk("rst_p_stall", {31'd0, p_stall}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_x_rvalid", {31'd0, x_rvalid}, 32'd0);
        chk("rst_x_rdata", x_rdata, 32'd0);
        hard_reset();

        // Idle pipeline, external read.
        poke(12'h010, 32'hDEADBEEF);
        step(IDLE, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 32'h0));
        step(IDLE, IDLE);

        // Starvation: external write forced through after STARVE_LIMIT refusals.
        pr = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        x  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h020, 32'h00000055);
        repeat (STARVE_LIMIT + 1) step(pr, x);
        step(pr, IDLE);
        w = {dm[12'h023], dm[12'h022], dm[12'h021], dm[12'h020]};
        chk("starve_mem20", w, 32'h00000055);

        // Simultaneous write contention at 0x40.
        p = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h040, 32'h11111111);
        x = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h040, 32'h22222222);
        repeat (STARVE_LIMIT) step(p, x);
        step(p, x);
        w = {dm[12'h043], dm[12'h042], dm[12'h041], dm[12'h040]};
        chk("contend_x_wins", w, 32'h22222222);
        step(p, IDLE);
        w = {dm[12'h043], dm[12'h042], dm[12'h041], dm[12'h040]};
        chk("contend_p_final", w, 32'h11111111);

        // Locked burst capped at MAX_BURST under continuous pipeline traffic.
        stall_cnt = 0;
        for (int i = 0; i < STARVE_LIMIT + MAX_BURST + 2; i++)
            step(pr, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'(12'h100 + 12'(4 * i)), $urandom));
        chk("burst_stall_cycles", 32'(stall_cnt), 32'(MAX_BURST));
        hard_reset();

        // Burst gap: pipeline byte store slips in while x_valid drops.
        step(IDLE, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h010, 32'h0));
        step(IDLE, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h014, 32'h0));
        step(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h003, 32'h000000AB), IDLE);
        chk("gap_sb_byte", {24'd0, dm[12'h003]}, 32'h000000AB);
        step(pr, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h018, 32'h0));
        hard_reset();

        // Reset during beat 3 of a locked write burst.
        step(IDLE, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h080, 32'hA0A0A0A0));
        step(IDLE, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h084, 32'hA1A1A1A1));
        apply(pr, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h088, 32'hA2A2A2A2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("midrst_x_ready", {31'd0, x_ready}, 32'd0);
        chk("midrst_x_rvalid", {31'd0, x_rvalid}, 32'd0);
        hard_reset();
        repeat (STARVE_LIMIT + 2)
            step(pr, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h08C, 32'h0));
        step(IDLE, IDLE);

        // Randomized traffic; stalled or refused requesters hold their request.
        p = IDLE;
        x = IDLE;
        for (int i = 0; i < 600; i++) begin
            if (!m_pstalled) p = rnd_req(1'b0);
            if (!m_xrefused) x = rnd_req(1'b1);
            step(p, x);
        end
        step(IDLE, IDLE);
        step(IDLE, IDLE);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        for (int a = 0; a < 512; a += 4) begin
            chk($sformatf("mem_%0h", a),
                {dm[a + 3], dm[a + 2], dm[a + 1], dm[a]},
                {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Single-port data-memory arbiter placed between the MEM stage and the 4 KB data memory (`dm_4k`). It shares that memory with an external requester (loader/DMA/debug) using a valid/ready handshake. The pipeline has priority, with two exceptions: a starvation counter forces single external beats, and an external requester may hold a bounded locked burst. When the pipeline loses arbitration, the block stalls it.

## Interface
Parameters:
- `AW`, default 12: memory byte-address width.
- `STARVE_LIMIT`, default 4: consecutive refused external cycles before a forced external grant. Legal range is 1..15.
- `MAX_BURST`, default 8: maximum beats in one locked burst. Legal range is 1..255.

Ports. Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `p_valid` in 1: MEM stage has a load or store this cycle.
- `p_we` in 1: pipeline store.
- `p_sb`, `p_lb`, `p_lbu` in 1 each: pipeline byte controls.
- `p_addr` in AW: pipeline address.
- `p_wdata` in 32: pipeline store data, already forwarded.
- `p_rdata` out 32: memory read data, combinational passthrough.
- `p_stall` out 1: pipeline access is not performed this cycle; the MEM stage must hold.
- `x_valid`, `x_we`, `x_sb`, `x_lb`, `x_lbu` in 1 each: external request and its controls.
- `x_lock` in 1: request a locked burst, or continue one.
- `x_addr` in AW: external address.
- `x_wdata` in 32: external write data.
- `x_ready` out 1: external beat is accepted when `x_valid && x_ready`.
- `x_rdata` out 32: registered read data of the last accepted external beat.
- `x_rvalid` out 1: one-cycle pulse, the cycle after every accepted external beat (reads and writes).
- `mem_addr` out AW, `mem_wdata` out 32, `mem_we` out 1, `mem_sb`/`mem_lb`/`mem_lbu` out 1 each: drive the dm port.
- `mem_rdata` in 32: combinational read data from dm.

## Operation
- State register has two states: ARB and XLOCK. Counters:
  - `starve_cnt`, 4 bits, saturating at STARVE_LIMIT.
  - `beat_cnt`, 8 bits.
- `x_ready` is 1 in XLOCK. In ARB it is `!p_valid || starve_cnt == STARVE_LIMIT`.
- `grant_x = x_valid && x_ready`; `p_stall = p_valid && grant_x`.
- Memory mux:
  - When `grant_x` is 1, the `mem_*` outputs take the x-side values.
  - Otherwise they take the p-side values, with `mem_we = p_valid && p_we`.
  - `mem_we` is 0 whenever neither side is valid, and 0 while `rst_n` is low.
- `p_rdata` is always `mem_rdata`. It is meaningful only when `p_valid && !p_stall`.
- Starvation in ARB:
  - `x_valid && !x_ready` increments `starve_cnt`, saturating.
  - Any `grant_x` clears it.
  - `starve_cnt` is held at 0 while in XLOCK.
- Transition ARB→XLOCK: on `grant_x && x_lock` with MAX_BURST > 1. `beat_cnt` loads 1.
- XLOCK behaviour:
  - Each `grant_x` increments `beat_cnt`.
  - Go to ARB when `grant_x && (!x_lock || beat_cnt + 1 == MAX_BURST)`, or when `x_valid == 0`.
  - If `x_valid == 0` in XLOCK, the pipeline uses memory in that cycle with no stall.
- On a burst exit caused by beat count, `starve_cnt` is 0. The pipeline therefore wins the next cycle if `p_valid` is set.
- On `grant_x`, `x_rdata <= mem_rdata` (the value loaded for reads; don't-care for writes) and `x_rvalid <= 1`. Otherwise `x_rvalid <= 0` and `x_rdata` holds.
- Stalled pipeline: the MEM stage holds its inputs. A stalled store is not written until it is granted.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State is ARB; `starve_cnt`, `beat_cnt`, `x_rdata` and `x_rvalid` are 0.
  - `x_ready`, `p_stall` and `mem_we` are forced to 0 while reset is asserted.
- Pipeline access: zero added latency. The write commits at the edge ending the granted cycle; read data is combinational in the same cycle.
- External access: accepted at edge T. For reads, `x_rdata` is valid with `x_rvalid = 1` during cycle T+1.
- Back-to-back external beats are allowed every cycle while `x_ready` is 1.
- Worst-case pipeline stall is MAX_BURST cycles per burst, or 1 cycle per forced starvation grant.
- Worst-case external wait under continuous `p_valid` is STARVE_LIMIT cycles.
- Reset mid-burst: drop to ARB immediately. An in-flight `x_rvalid` is lost and no `mem_we` is issued.

## Test plan
- **Idle pipeline, external read.** Preload 0x10 with 0xDEADBEEF. Set `p_valid = 0` and present an x read of 0x10. Required: `x_ready = 1`; at the next cycle `x_rvalid = 1` and `x_rdata = 0xDEADBEEF`; `p_stall = 0`.
- **Starvation.** Hold `p_valid = 1` continuously and hold `x_valid = 1`, x write of 0x55 at 0x20. Required: `x_ready = 0` for 4 cycles; in cycle 5 `x_ready = 1` and `p_stall = 1`; memory[0x20] = 0x55; `starve_cnt` returns to 0.
- **Locked burst capped.** With `MAX_BURST = 8`, `x_lock = 1` and `x_valid = 1` for 12 cycles, and `p_valid = 1`. Required: 8 consecutive x beats with `p_stall = 1`; then 1 cycle with `p_stall = 0`; then pipeline priority resumes.
- **Burst gap.** In XLOCK, drop `x_valid` for 1 cycle while `p_valid = 1` with a `p_sb` store of 0xAB to 0x3. Required: store performed, `p_stall = 0`, state returns to ARB.
- **Simultaneous write contention.** In the same cycle, pipeline stores 0x11111111 and x writes 0x22222222 to address 0x40, with `starve_cnt = STARVE_LIMIT`. Required: x wins; memory[0x40] = 0x22222222; in the next cycle the pipeline store lands and the final value is 0x11111111.
- **Reset mid-burst.** Assert `rst_n = 0` during beat 3 of a burst. Required: `mem_we = 0`, `x_ready = 0` and `x_rvalid = 0` immediately; after release the state is ARB and the counters are 0.
